// File: rtl/game_pkg.sv
// Shared types and constants for the number-guessing game round controller.
// Difficulty-to-budget mapping lives here so the display logic can reuse it.
package game_pkg;

    localparam int TIME_W = 7;

    localparam int T_EASY = 30;
    localparam int T_MED  = 60;
    localparam int T_HARD = 90;

    localparam int PENALTY_S_DEF   = 5;
    localparam int MAX_GUESSES_DEF = 10;
    localparam int WARN_S_DEF      = 10;

    localparam logic [1:0] DIFF_EASY = 2'd1;
    localparam logic [1:0] DIFF_MED  = 2'd2;
    localparam logic [1:0] DIFF_HARD = 2'd3;

    localparam logic CAUSE_TIME    = 1'b0;
    localparam logic CAUSE_GUESSES = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        WIN  = 3'd2,
        LOSE = 3'd3
    } state_e;

    function automatic logic [TIME_W-1:0] diff_to_seconds(input logic [1:0] max_digit);
        logic [TIME_W-1:0] secs;
        case (max_digit)
            DIFF_EASY: secs = TIME_W'(T_EASY);
            DIFF_MED:  secs = TIME_W'(T_MED);
            DIFF_HARD: secs = TIME_W'(T_HARD);
            default:   secs = '0;
        endcase
        return secs;
    endfunction

endpackage

// File: rtl/game_round_ctrl_countdown.sv
// Round timer: loadable down-counter with saturating multi-second decrement.
// zero_next tells the FSM whether the pending decrement would reach zero.
module round_countdown
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic [TIME_W-1:0] dec_amt,
    input  logic              hold,
    output logic [TIME_W-1:0] time_left,
    output logic              zero_next
);

    logic [TIME_W-1:0] time_left_q;
    logic [TIME_W-1:0] time_left_d;

    always_comb begin
        time_left_d = time_left_q;
        if (load) begin
            time_left_d = load_val;
        end else if (!hold) begin
            time_left_d = (time_left_q > dec_amt) ? (time_left_q - dec_amt) : '0;
        end
    end

    assign zero_next = (time_left_q <= dec_amt);
    assign time_left = time_left_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_left_q <= '0;
        end else begin
            time_left_q <= time_left_d;
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the guessing game: owns the round timer, wrong-guess
// counter and the win/lose decision feeding the display logic.
//
// state | meaning
// IDLE  | no round active, waiting for start
// RUN   | round in progress, timer counting down
// WIN   | correct guess seen, time and count frozen
// LOSE  | time expired or guesses exhausted, frozen
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int PENALTY_S   = PENALTY_S_DEF,
    parameter int MAX_GUESSES = MAX_GUESSES_DEF,
    parameter int WARN_S      = WARN_S_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        max_digit,
    input  logic              start,
    input  logic              abort,
    input  logic              sec_tick,
    input  logic              guess_valid,
    input  logic              guess_correct,
    output state_e            state,
    output logic [TIME_W-1:0] time_left,
    output logic [3:0]        guess_count,
    output logic              running,
    output logic              warn,
    output logic              win,
    output logic              lose,
    output logic              lose_cause,
    output logic              done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [3:0]        guess_count_q, guess_count_d;
    logic              lose_cause_q, lose_cause_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cd_load;
    logic [TIME_W-1:0] cd_load_val;
    logic [TIME_W-1:0] cd_dec_amt;
    logic              cd_hold;
    logic              cd_zero_next;
    logic [3:0]        guess_inc;

    assign cd_dec_amt = (sec_tick    ? TIME_W'(1)         : '0)
                      + (guess_valid ? TIME_W'(PENALTY_S) : '0);
    assign guess_inc  = guess_count_q + 4'd1;

    round_countdown u_countdown (
        .clk       (clk),
        .rst_n     (reset_n),
        .load      (cd_load),
        .load_val  (cd_load_val),
        .dec_amt   (cd_dec_amt),
        .hold      (cd_hold),
        .time_left (time_left),
        .zero_next (cd_zero_next)
    );

    always_comb begin
        state_d       = state_q;
        guess_count_d = guess_count_q;
        lose_cause_d  = lose_cause_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        cd_load       = 1'b0;
        cd_load_val   = '0;
        cd_hold       = 1'b1;

        case (state_q)
            RUN: begin
                if (abort) begin
                    state_d       = IDLE;
                    cd_load       = 1'b1;
                    guess_count_d = '0;
                end else if (guess_valid && guess_correct) begin
                    state_d = WIN;
                    done_d  = 1'b1;
                end else begin
                    cd_hold = 1'b0;
                    if (guess_valid) begin
                        guess_count_d = guess_inc;
                    end
                    // Guess exhaustion outranks a simultaneous timeout.
                    if (guess_valid && (guess_inc == 4'(MAX_GUESSES))) begin
                        state_d      = LOSE;
                        lose_cause_d = CAUSE_GUESSES;
                        done_d       = 1'b1;
                    end else if (cd_zero_next) begin
                        state_d      = LOSE;
                        lose_cause_d = CAUSE_TIME;
                        done_d       = 1'b1;
                    end
                end
            end
            IDLE, WIN, LOSE: begin
                if (start) begin
                    if (max_digit != 2'd0) begin
                        state_d       = RUN;
                        cd_load       = 1'b1;
                        cd_load_val   = diff_to_seconds(max_digit);
                        guess_count_d = '0;
                        lose_cause_d  = CAUSE_TIME;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            guess_count_q <= '0;
            lose_cause_q  <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            guess_count_q <= guess_count_d;
            lose_cause_q  <= lose_cause_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign state       = state_q;
    assign guess_count = guess_count_q;
    assign running     = (state_q == RUN);
    assign warn        = (state_q == RUN) && (time_left <= TIME_W'(WARN_S));
    assign win         = (state_q == WIN);
    assign lose        = (state_q == LOSE);
    assign lose_cause  = lose_cause_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: rule-level round model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_game_round_ctrl;
    import game_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  max_digit;
    logic        start, abort, sec_tick, guess_valid, guess_correct;
    state_e      state;
    logic [6:0]  time_left;
    logic [3:0]  guess_count;
    logic        running, warn, win, lose, lose_cause, done, cfg_err;

    int checks   = 0;
    int failures = 0;

    game_round_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .max_digit     (max_digit),
        .start         (start),
        .abort         (abort),
        .sec_tick      (sec_tick),
        .guess_valid   (guess_valid),
        .guess_correct (guess_correct),
        .state         (state),
        .time_left     (time_left),
        .guess_count   (guess_count),
        .running       (running),
        .warn          (warn),
        .win           (win),
        .lose          (lose),
        .lose_cause    (lose_cause),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round model: 0=idle 1=run 2=win 3=lose
    int m_st    = 0;
    int m_t     = 0;
    int m_g     = 0;
    int m_cause = 0;
    int m_done  = 0;
    int m_cfg   = 0;
    int budget[4] = '{0, 30, 60, 90};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; m_t = 0; m_g = 0; m_cause = 0; m_done = 0; m_cfg = 0;
        end else begin
            m_done = 0;
            m_cfg  = 0;
            if (m_st == 1) begin
                if (abort) begin
                    m_st = 0; m_t = 0; m_g = 0;
                end else if (guess_valid && guess_correct) begin
                    m_st = 2; m_done = 1;
                end else begin
                    int dec;
                    dec = (sec_tick ? 1 : 0) + (guess_valid ? 5 : 0);
                    m_t = (m_t > dec) ? m_t - dec : 0;
                    if (guess_valid) m_g = m_g + 1;
                    if (guess_valid && m_g == 10) begin
                        m_st = 3; m_cause = 1; m_done = 1;
                    end else if (m_t == 0) begin
                        m_st = 3; m_cause = 0; m_done = 1;
                    end
                end
            end else if (start) begin
                if (max_digit != 2'd0) begin
                    m_st = 1; m_t = budget[max_digit]; m_g = 0; m_cause = 0;
                end else begin
                    m_cfg = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_state", int'(state), m_st);
        chk("cyc_time_left", int'(time_left), m_t);
        chk("cyc_guess_count", int'(guess_count), m_g);
        chk("cyc_running", int'(running), (m_st == 1) ? 1 : 0);
        chk("cyc_warn", int'(warn), (m_st == 1 && m_t <= 10) ? 1 : 0);
        chk("cyc_win", int'(win), (m_st == 2) ? 1 : 0);
        chk("cyc_lose", int'(lose), (m_st == 3) ? 1 : 0);
        if (m_st == 3) chk("cyc_lose_cause", int'(lose_cause), m_cause);
        chk("cyc_done", int'(done), m_done);
        chk("cyc_cfg_err", int'(cfg_err), m_cfg);
    end

    // Apply one cycle of inputs, let the edge happen, return 1 time unit after it.
    task automatic step(input logic st, input logic [1:0] md, input logic ab,
                        input logic tk, input logic gv, input logic gc);
        start = st; max_digit = md; abort = ab;
        sec_tick = tk; guess_valid = gv; guess_correct = gc;
        @(posedge clk);
        #1;
        start = 0; abort = 0; sec_tick = 0; guess_valid = 0; guess_correct = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, max_digit, 0, 1, 0, 0);
    endtask

    initial begin
        reset_n = 1; max_digit = 0; start = 0; abort = 0;
        sec_tick = 0; guess_valid = 0; guess_correct = 0;
        #2 reset_n = 0;
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_time", int'(time_left), 0);
        chk("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1;

        // Medium round expires by time
        step(1, 2'd2, 0, 0, 0, 0);
        chk("med_state", int'(state), 1);
        chk("med_time", int'(time_left), 60);
        ticks(49);
        chk("med_time11", int'(time_left), 11);
        chk("med_warn_off", int'(warn), 0);
        ticks(1);
        chk("med_warn_on", int'(warn), 1);
        ticks(9);
        chk("med_time1", int'(time_left), 1);
        ticks(1);
        chk("med_expire_time", int'(time_left), 0);
        chk("med_expire_state", int'(state), 3);
        chk("med_expire_cause", int'(lose_cause), 0);
        chk("med_done", int'(done), 1);
        step(0, 2'd2, 0, 0, 0, 0);
        chk("med_done_clr", int'(done), 0);

        // Easy round won after 3 ticks
        step(1, 2'd1, 0, 0, 0, 0);
        chk("easy_time", int'(time_left), 30);
        chk("easy_lose_clr", int'(lose), 0);
        ticks(3);
        step(0, 2'd1, 0, 0, 1, 1);
        chk("easy_win_state", int'(state), 2);
        chk("easy_win_time", int'(time_left), 27);
        ticks(5);
        chk("easy_frozen", int'(time_left), 27);
        step(0, 2'd1, 1, 0, 0, 0);
        chk("abort_in_win", int'(state), 2);

        // Saturating penalty
        step(1, 2'd1, 0, 0, 0, 0);
        ticks(23);
        chk("sat_time7", int'(time_left), 7);
        step(0, 2'd1, 0, 1, 1, 0);
        chk("sat_time1", int'(time_left), 1);
        chk("sat_gc1", int'(guess_count), 1);
        step(0, 2'd1, 0, 0, 1, 0);
        chk("sat_time0", int'(time_left), 0);
        chk("sat_state", int'(state), 3);
        chk("sat_cause", int'(lose_cause), 0);

        // Guess exhaustion on hard
        step(1, 2'd3, 0, 0, 0, 0);
        chk("hard_time", int'(time_left), 90);
        for (int i = 0; i < 9; i++) begin
            step(0, 2'd3, 0, 0, 1, 0);
            step(0, 2'd3, 0, 0, 0, 0);
        end
        chk("hard_time9", int'(time_left), 45);
        chk("hard_gc9", int'(guess_count), 9);
        step(0, 2'd3, 0, 0, 1, 0);
        chk("hard_state", int'(state), 3);
        chk("hard_cause", int'(lose_cause), 1);
        chk("hard_gc10", int'(guess_count), 10);
        chk("hard_time10", int'(time_left), 40);

        // Correct guess beats final tick; rejected start
        step(1, 2'd1, 0, 0, 0, 0);
        ticks(29);
        chk("last_time1", int'(time_left), 1);
        step(0, 2'd1, 0, 1, 1, 1);
        chk("last_win", int'(state), 2);
        chk("last_time", int'(time_left), 1);
        step(1, 2'd0, 0, 0, 0, 0);
        chk("cfg_err_pulse", int'(cfg_err), 1);
        chk("cfg_err_state", int'(state), 2);
        step(0, 2'd0, 0, 0, 0, 0);
        chk("cfg_err_clr", int'(cfg_err), 0);

        // Asynchronous reset mid-round, then start-ignored and abort
        step(1, 2'd2, 0, 0, 0, 0);
        ticks(15);
        chk("mid_time45", int'(time_left), 45);
        #3 reset_n = 0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_time", int'(time_left), 0);
        chk("async_running", int'(running), 0);
        @(posedge clk);
        #3 reset_n = 1;
        step(0, 2'd2, 0, 0, 0, 0);
        chk("post_rst_state", int'(state), 0);
        step(1, 2'd2, 0, 0, 0, 0);
        step(1, 2'd1, 0, 1, 0, 0);
        chk("start_in_run", int'(time_left), 59);
        step(0, 2'd1, 1, 0, 0, 0);
        chk("abort_state", int'(state), 0);
        chk("abort_time", int'(time_left), 0);
        step(0, 2'd1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
